// File: rtl/frame_pkg.sv
// Shared constants for the frame RAM path: word tags, bus widths and arbiter FSM encoding.
package frame_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  localparam logic [1:0] TAG_SOF = 2'b01;
  localparam logic [1:0] TAG_EOF = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  function automatic logic is_eof_word(input logic wren, input logic [1:0] tag);
    return wren && (tag == TAG_EOF);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// 2-way round-robin picker: on a tie the requester that did not own last wins.
// Purely combinational; pick is meaningful only while vld is high.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       vld,
  output logic       pick
);

  assign vld  = |req;
  assign pick = (req == 2'b11) ? ~last_owner : req[1];

endmodule

// File: rtl/frame_ram_arbiter.sv
// Burst arbiter for the single-port frame RAM (M0 writer, M1 reader), 1-cycle registered RAM bus,
// one turnaround cycle between owners. `define ARB_TIMEOUT_EN adds the MAX_HOLD grant watchdog.
module frame_ram_arbiter #(
  parameter int ADDR_W   = frame_pkg::ADDR_W,
  parameter int DATA_W   = frame_pkg::DATA_W,
  parameter int MAX_HOLD = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wren,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  output logic [7:0]        frame_cnt,
  output logic              hold_err
);
  import frame_pkg::*;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_owner;
  logic       pick_vld;
  logic       pick;
  logic       m0_eof;
  logic       timeout;

  rr_pick2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .vld        (pick_vld),
    .pick       (pick)
  );

  assign m0_eof = is_eof_word(m0_wren, m0_wdata[DATA_W-1 -: 2]);
  assign m0_gnt = (state == ST_OWN0);
  assign m1_gnt = (state == ST_OWN1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (pick_vld) state_nxt = pick ? ST_OWN1 : ST_OWN0;
      ST_OWN0: if (!m0_req || m0_eof || timeout) state_nxt = ST_TURN;
      ST_OWN1: if (!m1_req || timeout) state_nxt = ST_TURN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // last_owner starts at M1 so that M0 wins the first tie out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_vld) last_owner <= pick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr  <= '0;
      ram_wren  <= 1'b0;
      ram_data  <= '0;
      frame_cnt <= '0;
    end else begin
      case (state)
        ST_OWN0: begin
          ram_addr <= m0_addr;
          ram_wren <= m0_wren;
          ram_data <= m0_wdata;
          if (m0_eof) frame_cnt <= frame_cnt + 8'd1;
        end
        ST_OWN1: begin
          ram_addr <= m1_addr;
          ram_wren <= 1'b0;
        end
        default: ram_wren <= 1'b0;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              owning;
  logic              hold_err_q;

  assign owning   = (state == ST_OWN0) || (state == ST_OWN1);
  // hold_cnt is the index of the current owned cycle; the last allowed one is MAX_HOLD-1.
  assign timeout  = owning && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign hold_err = hold_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= '0;
      hold_err_q <= 1'b0;
    end else begin
      if (owning && state_nxt == state) hold_cnt <= hold_cnt + 1'b1;
      else                              hold_cnt <= '0;
      if (timeout) hold_err_q <= 1'b1;
    end
  end
`else
  assign timeout  = 1'b0;
  assign hold_err = 1'b0;
`endif

endmodule
